par_worker: RTL and testbench

//  Responder side of the rd/act/done job handshake. The sequencing controller raises rd, then
//  act. par_worker reads NWORDS words from a 1-cycle-latency buffer and accumulates them into
//  acc. It then holds done until the controller drops rd.

---
 rtl/par_worker.sv | 115 +++++++++++
 tb/tb_par_worker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/par_worker.sv
// Job responder: on rd/act it streams NWORDS buffer words into acc,
// then holds done until the controller releases rd.
module par_worker #(
  parameter int DW = 8,
  parameter int NWORDS = 16,
  localparam int AW = $clog2(NWORDS),
  localparam int ACCW = DW + AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            rd,
  input  logic            act,
  input  logic [DW-1:0]   mem_data,
  output logic            mem_re,
  output logic [AW-1:0]   mem_addr,
  output logic [ACCW-1:0] acc,
  output logic            done,
  output logic            busy,
  output logic            aborted
);

  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_re_d;
  logic [ACCW-1:0] r_acc;
  logic            r_done;
  logic            r_busy;
  logic            r_aborted;

  logic [1:0]      w_nxt;
  logic            w_abort;
  logic            w_run;
  logic            w_last;
  logic            w_start;

  assign w_run   = (r_state == S_RUN);
  // All reads issued; the last word lands on the leaving edge
  // (or already did, if en stalled right after the final read).
  assign w_last  = (r_cnt == CW'(NWORDS));
  assign w_start = (r_state == S_IDLE) && (w_nxt == S_PREP);

  assign mem_re   = w_run & ~r_cnt[AW] & en;
  assign mem_addr = w_run ? r_cnt[AW-1:0] : '0;

  always_comb begin
    w_nxt   = r_state;
    w_abort = 1'b0;
    if (en) begin
      unique case (r_state)
        S_IDLE: begin
          if (rd) w_nxt = S_PREP;
        end
        S_PREP: begin
          if (!rd) begin
            w_nxt   = S_IDLE;
            w_abort = 1'b1;
          end else if (act) begin
            w_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (!rd) begin
            w_nxt   = S_IDLE;
            w_abort = 1'b1;
          end else if (w_last) begin
            w_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!rd) w_nxt = S_IDLE;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_re_d    <= 1'b0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_re_d    <= mem_re;
      r_aborted <= w_abort;
      r_done    <= (w_nxt == S_HOLD);
      r_busy    <= (w_nxt == S_PREP) || (w_nxt == S_RUN);
      if (w_start) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        if (mem_re) r_cnt <= r_cnt + CW'(1);
        if (r_re_d && w_run) r_acc <= r_acc + ACCW'(mem_data);
      end
    end
  end

  assign acc     = r_acc;
  assign done    = r_done;
  assign busy    = r_busy;
  assign aborted = r_aborted;

endmodule

// File: tb/tb_par_worker.sv
// Scoreboard bench for par_worker: random jobs, aborts, stalls
// and resets against a word-sum reference model.
module tb_par_worker;

  localparam int DW   = 8;
  localparam int NW   = 16;
  localparam int ACCW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic rd = 1'b0;
  logic act = 1'b0;
  logic [DW-1:0] mem_data = '0;
  logic mem_re;
  logic [3:0] mem_addr;
  logic [ACCW-1:0] acc;
  logic done, busy, aborted;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] bufm [NW];

  typedef struct {
    bit is_abort;
    int sum;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int exp_addr = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  par_worker #(.DW(DW), .NWORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rd(rd), .act(act),
    .mem_data(mem_data), .mem_re(mem_re), .mem_addr(mem_addr),
    .acc(acc), .done(done), .busy(busy), .aborted(aborted)
  );

  // 1-cycle latency buffer
  always @(posedge clk) begin
    if (mem_re) mem_data <= bufm[mem_addr];
  end

  task automatic check(input string nm, input longint a, input longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic push_exp(input bit ab, input int s);
    exp_t e;
    e.is_abort = ab;
    e.sum = s;
    sbq.push_back(e);
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < NW; k++) begin
      case (mode)
        0: bufm[k] = DW'(k + 1);
        1: bufm[k] = 8'hFF;
        default: bufm[k] = DW'($urandom);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: address order and job-end events against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) exp_addr = 0;
      if (mem_re) begin
        check("mem_addr", mem_addr, exp_addr);
        exp_addr++;
      end
      if ((done && !prev_done) || aborted) begin
        if (sbq.size() == 0) begin
          check("event_without_expectation", sbq.size(), 1);
        end else begin
          mon_e = sbq.pop_front();
          check("event_kind_abort", aborted, mon_e.is_abort);
          check("acc", acc, mon_e.sum);
        end
      end
    end
    prev_done = done;
  end

  task automatic run_job(input bit abort_prep, input int abort_m,
                         input int s, input int l,
                         input bit act_with_rd, input int hold);
    int sum;
    int n;
    bit seen;
    sum = 0;
    en = 1'b1;
    rd = 1'b1;
    act = act_with_rd;
    tick();
    if (abort_prep) begin
      push_exp(1'b1, 0);
      rd = 1'b0;
      act = 1'b0;
      tick();
      check("prep_abort_pulse", aborted, 1);
      tick();
      check("prep_abort_end", aborted, 0);
      check("prep_abort_busy", busy, 0);
      return;
    end
    act = 1'b1;
    tick();
    if (abort_m > 0) begin
      for (int k = 0; k <= abort_m - 2; k++) sum += bufm[k];
      push_exp(1'b1, sum);
      for (int k = 1; k < abort_m; k++) begin
        act = 1'($urandom);
        tick();
      end
      rd = 1'b0;
      tick();
      check("run_abort_pulse", aborted, 1);
      check("run_abort_no_done", done, 0);
      tick();
      check("run_abort_end", aborted, 0);
      check("run_abort_busy", busy, 0);
      check("run_abort_re", mem_re, 0);
      act = 1'b0;
      return;
    end
    for (int k = 0; k < NW; k++) sum += bufm[k];
    push_exp(1'b0, sum);
    n = 1;
    seen = 1'b0;
    while (!seen && n <= 60) begin
      en = !(n >= s && n < s + l);
      act = 1'($urandom);
      tick();
      if (done) seen = 1'b1;
      else n++;
    end
    en = 1'b1;
    check("done_latency", n, 17 + l);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("done_held", done, 1);
    end
    rd = 1'b0;
    act = 1'b0;
    tick();
    check("done_release", done, 0);
    check("release_busy", busy, 0);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_acc", acc, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_aborted", aborted, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();

    fill(0);
    run_job(1'b0, 0, 0, 0, 1'b0, 0);
    fill(0);
    run_job(1'b0, 0, 0, 0, 1'b0, 10);
    fill(2);
    run_job(1'b0, 5, 0, 0, 1'b0, 0);
    run_job(1'b0, 0, 0, 0, 1'b0, 2);
    fill(1);
    run_job(1'b0, 0, 6, 3, 1'b0, 1);
    run_job(1'b0, 0, 17, 2, 1'b0, 0);
    fill(2);
    run_job(1'b0, 0, 0, 0, 1'b1, 0);
    run_job(1'b1, 0, 0, 0, 1'b0, 0);

    // reset while word 7 is being read
    fill(0);
    en = 1'b1;
    rd = 1'b1;
    tick();
    act = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      if (mem_re && mem_addr == 4'd7) break;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_acc", acc, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_aborted", aborted, 0);
    check("midrst_mem_re", mem_re, 0);
    check("midrst_mem_addr", mem_addr, 0);
    rd = 1'b0;
    act = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    run_job(1'b0, 0, 0, 0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      fill(2);
      r = $urandom_range(0, 3);
      if (r == 0)
        run_job(1'b0, $urandom_range(1, 16), 0, 0, 1'b0, 0);
      else if (r == 1)
        run_job(1'b1, 0, 0, 0, 1'b0, 0);
      else
        run_job(1'b0, 0, $urandom_range(2, 17), $urandom_range(0, 4),
                1'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (4) tick();
    check("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
